// File: rtl/chacha_inv_permute.sv
// chacha_inv_permute: iterative inverse ChaCha permutation, one inverse round per cycle.
// Optional constant check on recovered words 0-3 enabled by CHACHA_INV_CHECK_EN.
module chacha_inv_permute #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state,
  output logic         busy
`ifdef CHACHA_INV_CHECK_EN
  ,
  output logic         const_err
`endif
);
  localparam int CW = $clog2(ROUNDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    rcnt_q, rcnt_d;
  logic [15:0][31:0] st_q, st_d, rc, rd, r;
  logic             accept, fin, leave;
  function automatic logic [127:0] iqr(input logic [31:0] a, b, c, d);
    b = {b[6:0], b[31:7]} ^ c;
    c = c - d;
    d = {d[7:0], d[31:8]} ^ a;
    a = a - b;
    b = {b[11:0], b[31:12]} ^ c;
    c = c - d;
    d = {d[15:0], d[31:16]} ^ a;
    a = a - b;
    return {a, b, c, d};
  endfunction
  // Column and diagonal variants are both built; the round parity picks one.
  for (genvar g = 0; g < 4; g++) begin : grp
    assign {rc[g], rc[4+g], rc[8+g], rc[12+g]} =
      iqr(st_q[g], st_q[4+g], st_q[8+g], st_q[12+g]);
    assign {rd[g], rd[4+(g+1)%4], rd[8+(g+2)%4], rd[12+(g+3)%4]} =
      iqr(st_q[g], st_q[4+(g+1)%4], st_q[8+(g+2)%4], st_q[12+(g+3)%4]);
  end
  assign r         = rcnt_q[0] ? rd : rc;
  assign accept    = state_q == IDLE && in_valid;
  assign fin       = state_q == RUN && rcnt_q == '0;
  assign leave     = state_q == DONE && out_ready;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_state = st_q;
  always_comb begin
    state_d = accept ? RUN : fin ? DONE : leave ? IDLE : state_q;
    st_d    = accept ? in_state : state_q == RUN ? r : st_q;
    rcnt_d  = accept ? CW'(ROUNDS - 1) : (state_q == RUN && !fin) ? rcnt_q - CW'(1) : rcnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rcnt_q  <= rcnt_d;
    end
  end
`ifdef CHACHA_INV_CHECK_EN
  logic const_err_q, const_err_d;
  assign const_err_d = fin ? (r[3:0] != {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865})
                     : leave ? 1'b0 : const_err_q;
  always_ff @(posedge clk) begin
    if (rst) const_err_q <= 1'b0;
    else const_err_q <= const_err_d;
  end
  assign const_err = const_err_q;
`endif
endmodule
